// File: rtl/mem_stage.sv
// RV32I MEM stage: drives data-memory loads and stores over req/ack, steers byte lanes,
// and produces the MEM/WB register. States: IDLE | decode/retire, REQ | waiting on dmem_ack.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_pc,
    input  logic [31:0] ex_mem_pc_4,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rs2_data,
    input  logic [4:0]  ex_mem_rd,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_mem_read_en,
    input  logic        ex_mem_mem_write_en,
    input  logic        ex_mem_reg_write_en,
    input  logic [1:0]  ex_mem_mem_to_reg_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] mem_wb_pc,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write_en,
    output logic [31:0] mem_wb_write_data,
    output logic        mem_wb_exception,
    output logic        mem_wb_exc_cause
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
    localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  rd_q, rd_d;
    logic        rwe_q, rwe_d;
    logic [31:0] data_q, data_d;
    logic        exc_q, exc_d;
    logic        cause_q, cause_d;

    logic        is_byte, is_half, is_word;
    logic [1:0]  byte_off;
    logic        access, misaligned;
    logic [31:0] rdata_sh, load_data, wb_data;
    logic        req_c, stall_c;

    assign is_byte  = (ex_mem_funct3[1:0] == 2'b00);
    assign is_half  = (ex_mem_funct3[1:0] == 2'b01);
    assign is_word  = ~is_byte & ~is_half;
    assign byte_off = ex_mem_alu_result[1:0];
    assign access   = ex_mem_mem_read_en | ex_mem_mem_write_en;
    assign misaligned = (is_half & byte_off[0]) | (is_word & (byte_off != 2'b00));

    // funct3[2] marks the unsigned load variants
    assign rdata_sh = dmem_rdata >> {byte_off, 3'b000};
    always_comb begin
        load_data = rdata_sh;
        if (is_byte) begin
            load_data = {{24{rdata_sh[7] & ~ex_mem_funct3[2]}}, rdata_sh[7:0]};
        end else if (is_half) begin
            load_data = {{16{rdata_sh[15] & ~ex_mem_funct3[2]}}, rdata_sh[15:0]};
        end
    end

    always_comb begin
        case (ex_mem_mem_to_reg_sel)
            2'd0:    wb_data = ex_mem_alu_result;
            2'd1:    wb_data = load_data;
            2'd2:    wb_data = ex_mem_pc_4;
            default: wb_data = 32'd0;
        endcase
    end

    always_comb begin
        dmem_wdata = ex_mem_rs2_data;
        dmem_wstrb = 4'b1111;
        if (is_byte) begin
            dmem_wdata = {4{ex_mem_rs2_data[7:0]}};
            dmem_wstrb = 4'b0001 << byte_off;
        end else if (is_half) begin
            dmem_wdata = {2{ex_mem_rs2_data[15:0]}};
            dmem_wstrb = 4'b0011 << byte_off;
        end
        if (!ex_mem_mem_write_en) begin
            dmem_wstrb = 4'b0000;
        end
    end

    assign dmem_addr = ex_mem_alu_result;
    assign dmem_we   = ex_mem_mem_write_en;
    assign dmem_req  = req_c & ~rst;
    assign stall     = stall_c & ~rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        // every cycle is either a retire or a bubble; bubble is the default
        pc_d    = pc_q;
        rd_d    = rd_q;
        data_d  = data_q;
        rwe_d   = 1'b0;
        exc_d   = 1'b0;
        cause_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    state_d = S_REQ;
                    cnt_d   = 32'd0;
                    stall_c = 1'b1;
                end else begin
                    pc_d   = ex_mem_pc;
                    rd_d   = ex_mem_rd;
                    data_d = wb_data;
                    rwe_d  = ex_mem_reg_write_en & ~(access & misaligned);
                    exc_d  = access & misaligned;
                end
            end
            S_REQ: begin
                req_c = 1'b1;
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                    pc_d    = ex_mem_pc;
                    rd_d    = ex_mem_rd;
                    data_d  = wb_data;
                    rwe_d   = ex_mem_reg_write_en;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                    pc_d    = ex_mem_pc;
                    rd_d    = ex_mem_rd;
                    data_d  = wb_data;
                    exc_d   = 1'b1;
                    cause_d = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            pc_q    <= 32'd0;
            rd_q    <= 5'd0;
            rwe_q   <= 1'b0;
            data_q  <= 32'd0;
            exc_q   <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rwe_q   <= rwe_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
        end
    end

    assign mem_wb_pc           = pc_q;
    assign mem_wb_rd           = rd_q;
    assign mem_wb_reg_write_en = rwe_q;
    assign mem_wb_write_data   = data_q;
    assign mem_wb_exception    = exc_q;
    assign mem_wb_exc_cause    = cause_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: an instruction-level model predicts stall/req/bus and
// the MEM/WB register each cycle; a few literal values pin the model.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] ex_mem_pc, ex_mem_pc_4, ex_mem_alu_result, ex_mem_rs2_data;
    logic [4:0]  ex_mem_rd;
    logic [2:0]  ex_mem_funct3;
    logic        ex_mem_mem_read_en, ex_mem_mem_write_en, ex_mem_reg_write_en;
    logic [1:0]  ex_mem_mem_to_reg_sel;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] mem_wb_pc;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write_en;
    logic [31:0] mem_wb_write_data;
    logic        mem_wb_exception, mem_wb_exc_cause;

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_pc(ex_mem_pc), .ex_mem_pc_4(ex_mem_pc_4),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_funct3(ex_mem_funct3),
        .ex_mem_mem_read_en(ex_mem_mem_read_en), .ex_mem_mem_write_en(ex_mem_mem_write_en),
        .ex_mem_reg_write_en(ex_mem_reg_write_en), .ex_mem_mem_to_reg_sel(ex_mem_mem_to_reg_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall),
        .mem_wb_pc(mem_wb_pc), .mem_wb_rd(mem_wb_rd),
        .mem_wb_reg_write_en(mem_wb_reg_write_en), .mem_wb_write_data(mem_wb_write_data),
        .mem_wb_exception(mem_wb_exception), .mem_wb_exc_cause(mem_wb_exc_cause)
    );

    typedef struct {
        logic        rwe;
        logic        exc;
        logic        chk_cause;
        logic        cause;
        logic        chk_id;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        chk_data;
        logic [31:0] data;
    } wb_t;

    localparam wb_t WB_BUBBLE = '{rwe: 1'b0, exc: 1'b0, chk_cause: 1'b0, cause: 1'b0, chk_id: 1'b0,
                                  pc: 32'd0, rd: 5'd0, chk_data: 1'b0, data: 32'd0};
    localparam wb_t WB_ZERO   = '{rwe: 1'b0, exc: 1'b0, chk_cause: 1'b1, cause: 1'b0, chk_id: 1'b1,
                                  pc: 32'd0, rd: 5'd0, chk_data: 1'b1, data: 32'd0};

    int n_tests = 0;
    int n_fail  = 0;

    logic        cmp_en = 1'b0;
    logic        chk_stall = 1'b0, e_stall = 1'b0, e_req = 1'b0;
    logic        chk_bus = 1'b0, e_we = 1'b0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
    logic [3:0]  e_wstrb = 4'd0;
    wb_t         e_wb = WB_BUBBLE;
    wb_t         p_wb = WB_BUBBLE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (chk_stall) check("stall", 32'(stall), 32'(e_stall));
            check("dmem_req", 32'(dmem_req), 32'(e_req));
            if (chk_bus) begin
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_we", 32'(dmem_we), 32'(e_we));
                check("dmem_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
                if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
            end
            check("mem_wb_reg_write_en", 32'(mem_wb_reg_write_en), 32'(e_wb.rwe));
            check("mem_wb_exception", 32'(mem_wb_exception), 32'(e_wb.exc));
            if (e_wb.chk_cause) check("mem_wb_exc_cause", 32'(mem_wb_exc_cause), 32'(e_wb.cause));
            if (e_wb.chk_id) begin
                check("mem_wb_pc", mem_wb_pc, e_wb.pc);
                check("mem_wb_rd", 32'(mem_wb_rd), 32'(e_wb.rd));
            end
            if (e_wb.chk_data) check("mem_wb_write_data", mem_wb_write_data, e_wb.data);
        end
    end

    // access size in bytes; undefined encodings behave as word
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int unsigned v;
        int          sz;
        sz = size_of(f3);
        v  = word >> (8 * (addr % 4));
        if (sz == 1) begin
            v = v % 256;
            if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v % 65536;
            if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e_wb = p_wb;
    endtask

    // ack_at: REQ cycle carrying dmem_ack (0 = never); stop_at: REQ cycle at which to abandon (0 = none)
    task automatic run(input logic [2:0] f3, input logic rd_en, input logic wr_en, input logic rwe,
                       input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [31:0] rdata, input logic [4:0] rd,
                       input int ack_at, input int stop_at);
        int          sz;
        bit          acc, mis;
        logic [31:0] wbv;
        wb_t         done, tmo;
        ex_mem_pc = pc; ex_mem_pc_4 = pc + 32'd4; ex_mem_alu_result = alu; ex_mem_rs2_data = rs2;
        ex_mem_rd = rd; ex_mem_funct3 = f3; ex_mem_mem_read_en = rd_en; ex_mem_mem_write_en = wr_en;
        ex_mem_reg_write_en = rwe; ex_mem_mem_to_reg_sel = sel;
        dmem_rdata = rdata; dmem_ack = 1'b0;
        sz  = size_of(f3);
        acc = rd_en || wr_en;
        mis = acc && ((alu % sz) != 0);
        case (sel)
            2'd0:    wbv = alu;
            2'd1:    wbv = load_val(rdata, alu, f3);
            2'd2:    wbv = pc + 32'd4;
            default: wbv = 32'd0;
        endcase
        done = '{rwe: rwe && !mis, exc: mis, chk_cause: 1'b1, cause: 1'b0, chk_id: 1'b1,
                 pc: pc, rd: rd, chk_data: rwe && !mis, data: wbv};
        tmo  = '{rwe: 1'b0, exc: 1'b1, chk_cause: 1'b1, cause: 1'b1, chk_id: 1'b1,
                 pc: pc, rd: rd, chk_data: 1'b0, data: 32'd0};
        chk_stall = 1'b1; chk_bus = 1'b0; e_req = 1'b0;
        if (!acc || mis) begin
            e_stall = 1'b0; p_wb = done; tick();
            return;
        end
        e_stall = 1'b1; p_wb = WB_BUBBLE; tick();
        chk_bus = 1'b1; e_req = 1'b1; e_addr = alu; e_we = wr_en;
        if (sz == 1)      e_wdata = (rs2 % 256) * 32'h0101_0101;
        else if (sz == 2) e_wdata = (rs2 % 65536) * 32'h0001_0001;
        else              e_wdata = rs2;
        e_wstrb = wr_en ? 4'((((1 << sz) - 1) << (alu % 4)) % 16) : 4'd0;
        for (int k = 1; k <= TMO; k++) begin
            if (k == stop_at) return;
            if (k == ack_at) begin
                dmem_ack = 1'b1; e_stall = 1'b0; p_wb = done; tick();
                dmem_ack = 1'b0;
                return;
            end else if (k == TMO) begin
                e_stall = 1'b0; p_wb = tmo; tick();
                return;
            end else begin
                e_stall = 1'b1; p_wb = WB_BUBBLE; tick();
            end
        end
    endtask

    task automatic drive_idle();
        ex_mem_pc = 32'd0; ex_mem_pc_4 = 32'd0; ex_mem_alu_result = 32'd0; ex_mem_rs2_data = 32'd0;
        ex_mem_rd = 5'd0; ex_mem_funct3 = 3'd0; ex_mem_mem_read_en = 1'b0; ex_mem_mem_write_en = 1'b0;
        ex_mem_reg_write_en = 1'b0; ex_mem_mem_to_reg_sel = 2'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        chk_stall = 1'b0; e_req = 1'b0; chk_bus = 1'b0;
        p_wb = WB_ZERO;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        p_wb = WB_ZERO;
        tick();
        cmp_en = 1'b1;
        do_reset();

        // ALU op, then the load family against one read word
        run(3'b000, 0, 0, 1, 2'd0, 32'h100, 32'h55, 32'd0, 32'd0, 5'd3, 0, 0);
        check("pin_add_data", mem_wb_write_data, 32'h55);
        check("pin_add_rwe", 32'(mem_wb_reg_write_en), 32'd1);
        run(3'b000, 1, 0, 1, 2'd1, 32'h104, 32'h1003, 32'd0, 32'h80AA_BBCC, 5'd5, 2, 0);
        check("pin_lb", mem_wb_write_data, 32'hFFFF_FF80);
        run(3'b100, 1, 0, 1, 2'd1, 32'h108, 32'h1003, 32'd0, 32'h80AA_BBCC, 5'd6, 1, 0);
        check("pin_lbu", mem_wb_write_data, 32'h0000_0080);
        run(3'b001, 1, 0, 1, 2'd1, 32'h10C, 32'h1002, 32'd0, 32'h80AA_BBCC, 5'd7, 3, 0);
        check("pin_lh", mem_wb_write_data, 32'hFFFF_80AA);
        run(3'b101, 1, 0, 1, 2'd1, 32'h110, 32'h1002, 32'd0, 32'h80AA_BBCC, 5'd8, 1, 0);
        check("pin_lhu", mem_wb_write_data, 32'h0000_80AA);
        run(3'b010, 1, 0, 1, 2'd1, 32'h114, 32'h1000, 32'd0, 32'h80AA_BBCC, 5'd9, 1, 0);
        run(3'b000, 1, 0, 1, 2'd1, 32'h118, 32'h1001, 32'd0, 32'h80AA_BBCC, 5'd10, 1, 0);
        run(3'b100, 1, 0, 1, 2'd1, 32'h11C, 32'h1000, 32'd0, 32'h80AA_BBCC, 5'd11, 2, 0);
        run(3'b111, 1, 0, 1, 2'd1, 32'h120, 32'h1004, 32'd0, 32'h1234_5678, 5'd12, 1, 0);

        // stores
        run(3'b001, 0, 1, 0, 2'd0, 32'h124, 32'h2002, 32'h1234_ABCD, 32'd0, 5'd0, 1, 0);
        run(3'b000, 0, 1, 0, 2'd0, 32'h128, 32'h2001, 32'h0000_00EF, 32'd0, 5'd0, 2, 0);
        run(3'b010, 0, 1, 0, 2'd0, 32'h12C, 32'h2004, 32'hDEAD_BEEF, 32'd0, 5'd0, 1, 0);

        // misaligned: no request, one-cycle exception
        run(3'b010, 1, 0, 1, 2'd1, 32'h130, 32'h1002, 32'd0, 32'd0, 5'd4, 0, 0);
        check("pin_mis_exc", 32'(mem_wb_exception), 32'd1);
        check("pin_mis_cause", 32'(mem_wb_exc_cause), 32'd0);
        run(3'b001, 1, 0, 1, 2'd1, 32'h134, 32'h1001, 32'd0, 32'd0, 5'd4, 0, 0);
        run(3'b010, 0, 1, 0, 2'd0, 32'h138, 32'h2003, 32'h5555_AAAA, 32'd0, 5'd0, 0, 0);

        // x0 passthrough and sel 3
        run(3'b000, 0, 0, 1, 2'd0, 32'h13C, 32'h77, 32'd0, 32'd0, 5'd0, 0, 0);
        run(3'b000, 0, 0, 1, 2'd3, 32'h140, 32'h99, 32'd0, 32'd0, 5'd13, 0, 0);

        // bus timeout, then ack on the last allowed cycle
        run(3'b010, 1, 0, 1, 2'd1, 32'h144, 32'h1000, 32'd0, 32'h1111_2222, 5'd14, 0, 0);
        check("pin_tmo_exc", 32'(mem_wb_exception), 32'd1);
        check("pin_tmo_cause", 32'(mem_wb_exc_cause), 32'd1);
        run(3'b010, 1, 0, 1, 2'd1, 32'h148, 32'h1000, 32'd0, 32'h3333_4444, 5'd15, TMO, 0);
        check("pin_late_ack", mem_wb_write_data, 32'h3333_4444);

        // reset while waiting on memory, then a JAL writes the link value
        run(3'b010, 1, 0, 1, 2'd1, 32'h14C, 32'h1000, 32'd0, 32'd0, 5'd16, 0, 2);
        do_reset();
        run(3'b000, 0, 0, 1, 2'd2, 32'h200, 32'h1234, 32'd0, 32'd0, 5'd1, 0, 0);
        check("pin_jal", mem_wb_write_data, 32'h204);
        run(3'b000, 0, 0, 0, 2'd0, 32'h204, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
